mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//   Multicycle MULT/MULTU/DIV/DIVU engine for the MIPS datapath. Operands come
//   from registers A/B. The block owns the HI/LO registers. hi/lo feed the
//   4:1 write-back select mux, where mfhi/mflo pick them.
//   Start/done handshake with the control FSM; iterative, one bit per cycle.
// PARAMETERS
//   WIDTH  32  operand width; hi/lo each WIDTH bits; iteration count = WIDTH
// PORTS
//   clk         in   1      rising-edge clock; the only clock domain
//   reset_n     in   1      asynchronous, active-low reset
//   mult_start  in   1      start multiply; sampled only in IDLE
//   div_start   in   1      start divide; sampled only in IDLE
//   op_signed   in   1      1 = signed (mult/div), 0 = unsigned (multu/divu)
//   a           in   WIDTH  multiplicand / dividend; captured at start
//   b           in   WIDTH  multiplier / divisor; captured at start
//   busy        out  1      operation in progress (ITER or FIX)
//   done        out  1      1-cycle pulse; result registers just updated
//   div_zero    out  1      divide-by-zero flag, valid while done=1
//   hi          out  WIDTH  HI register: product[2W-1:W] / remainder
//   lo          out  WIDTH  LO register: product[W-1:0] / quotient
// BEHAVIOUR
//   Reset (async, reset_n=0): FSM->IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0.
//     All internal accumulators and counters are cleared. Removing reset is
//     synchronous to clk.
//   FSM states: IDLE, ITER, FIX, DONE.
//   - IDLE: on mult_start or div_start at edge k, capture a, b, op and op_signed.
//     For signed ops, capture magnitudes plus result-sign bits. Go to ITER with
//     count=0.
//     - Both starts high: multiply wins.
//     - div_start with b==0: go straight to DONE with div_zero=1.
//       hi and lo are NOT written.
//   - ITER: one shift-add (mult) or restore-subtract (div) step per cycle.
//     Operands are unsigned magnitudes. After WIDTH steps, go to FIX.
//   - FIX: apply signs, write hi/lo, go to DONE.
//   - DONE: done=1 for exactly one cycle, then IDLE.
//     A start sampled in DONE is ignored. Control must issue starts in IDLE.
//   Latency: done=1 in the cycle following edge k+WIDTH+2, i.e. 34 edges for
//     WIDTH=32. Divide-by-zero: done=1 after edge k+1.
//   busy=1 in ITER and FIX only. Starts while busy=1 are ignored; no queueing.
//   Operand changes after edge k have no effect on the result.
//   Arithmetic:
//   - mult: {hi,lo} = full 2*WIDTH product. Signed result is the two's
//     complement of the magnitude product when the operand signs differ.
//   - div: lo = quotient, truncated toward zero; hi = remainder, with the sign
//     of the dividend. Invariant: a == lo*b + hi.
//   - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wraps); div_zero=0.
//   - Unsigned ops never negate.
//   hi/lo hold their value between operations. mfhi/mflo read them at any time.
//   div_zero holds until the next accepted start, which clears it.
//   Reset mid-operation aborts: no done pulse, hi/lo=0.
// TESTING
//   1 multu a=7, b=6 -> done at edge k+34; hi=0x00000000, lo=0x0000002A; busy low.
//   2 mult a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1;
//     multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
//   3 div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF;
//     divu a=100, b=7 -> lo=14, hi=2.
//   4 divu a=100, b=0 with hi/lo preloaded -> done after edge k+1, div_zero=1,
//     hi/lo unchanged; next start clears div_zero.
//   5 div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0;
//     both starts high together -> multiply result.
//   6 start mid-op ignored (one done, result of first op only); reset_n low at
//     iteration 10 -> no done, hi=lo=0; next op after reset is correct.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the control FSM (master) and the multiply/divide engine (slave).
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic             mult_start;
  logic             div_start;
  logic             op_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output mult_start, div_start, op_signed, a, b,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  mult_start, div_start, op_signed, a, b,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; done pulses WIDTH+2 edges after the start edge.
// No backpressure: starts are sampled only in IDLE, anything else is dropped without queueing.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  mult_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic             r_neg_lo;
  logic             r_neg_hi;
  logic [WIDTH:0]   r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic               w_start;
  logic               w_is_div;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic [WIDTH:0]     w_nxt_hi;
  logic [WIDTH-1:0]   w_nxt_lo;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_rem_mag;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_quo;

  assign w_start  = (r_state == S_IDLE) && (bus.mult_start || bus.div_start);
  assign w_is_div = bus.div_start && !bus.mult_start;
  assign w_sa     = bus.op_signed & bus.a[WIDTH-1];
  assign w_sb     = bus.op_signed & bus.b[WIDTH-1];
  assign w_mag_a  = w_sa ? -bus.a : bus.a;
  assign w_mag_b  = w_sb ? -bus.b : bus.b;

  // Both ops share the accumulators: acc_lo starts as |a| (multiplier or dividend),
  // acc_hi starts at zero (partial product or partial remainder), opnd holds |b|.
  assign w_add   = r_acc_lo[0] ? (r_acc_hi + {1'b0, r_opnd}) : r_acc_hi;
  assign w_shift = {r_acc_hi[WIDTH-1:0], r_acc_lo[WIDTH-1]};
  assign w_diff  = {1'b0, w_shift} - {2'b00, r_opnd};

  always_comb begin
    w_nxt_hi = r_acc_hi;
    w_nxt_lo = r_acc_lo;
    if (r_is_div) begin
      if (!w_diff[WIDTH+1]) begin
        w_nxt_hi = w_diff[WIDTH:0];
        w_nxt_lo = {r_acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_nxt_hi = w_shift;
        w_nxt_lo = {r_acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_nxt_hi = {1'b0, w_add[WIDTH:1]};
      w_nxt_lo = {w_add[0], r_acc_lo[WIDTH-1:1]};
    end
  end

  assign w_prod     = {r_acc_hi[WIDTH-1:0], r_acc_lo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
  assign w_rem_mag  = r_acc_hi[WIDTH-1:0];
  assign w_rem      = r_neg_hi ? -w_rem_mag : w_rem_mag;
  assign w_quo      = r_neg_lo ? -r_acc_lo : r_acc_lo;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_lo   <= 1'b0;
      r_neg_hi   <= 1'b0;
      r_acc_hi   <= '0;
      r_acc_lo   <= '0;
      r_opnd     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_is_div <= w_is_div;
            r_neg_lo <= w_sa ^ w_sb;
            r_neg_hi <= w_sa & w_is_div;
            r_acc_hi <= '0;
            r_acc_lo <= w_mag_a;
            r_opnd   <= w_mag_b;
            r_cnt    <= '0;
            // Divide by zero skips the datapath entirely so HI/LO keep their value.
            if (w_is_div && (bus.b == '0)) begin
              r_div_zero <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_div_zero <= 1'b0;
              r_state    <= S_ITER;
            end
          end
        end
        S_ITER: begin
          r_acc_hi <= w_nxt_hi;
          r_acc_lo <= w_nxt_lo;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) r_state <= S_FIX;
        end
        S_FIX: begin
          {r_hi, r_lo} <= r_is_div ? {w_rem, w_quo} : w_prod_fix;
          r_state      <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (r_state == S_ITER) || (r_state == S_FIX);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;

endmodule
